// File: rtl/i2c_byte_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_byte_rx_if
// Brief    : Bus bundle between the I2C synchroniser side and i2c_byte_rx.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_byte_rx_if;
  logic       sda_in;
  logic       scl_in;
  logic       past_sda_in;
  logic       past_scl_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_hit;
  logic       rw;
  logic       start_det;
  logic       stop_det;
  logic       busy;

  modport master (
    output sda_in, scl_in, past_sda_in, past_scl_in,
    input  sda_oe, rx_data, rx_valid, addr_hit, rw, start_det, stop_det, busy
  );

  modport slave (
    input  sda_in, scl_in, past_sda_in, past_scl_in,
    output sda_oe, rx_data, rx_valid, addr_hit, rw, start_det, stop_det, busy
  );
endinterface
`default_nettype wire

// File: rtl/i2c_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_byte_rx
// Brief    : I2C target receive engine: START/STOP detect, address match,
//            write-byte capture and ACK generation on the open-drain enable.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_byte_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter bit         GEN_ACK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  i2c_byte_rx_if.slave io_bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_DATA     = 3'd3,
    S_DATA_ACK = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  state_t     r_state;
  logic [3:0] r_bcnt;
  logic [7:0] r_sreg;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_addr_hit;
  logic       r_rw;
  logic       r_start_det;
  logic       r_stop_det;
  logic       r_busy;

  logic w_start;
  logic w_stop;
  logic w_rise;
  logic w_fall;
  logic w_byte_done;

  assign w_start = io_bus.scl_in & io_bus.past_scl_in & io_bus.past_sda_in & ~io_bus.sda_in;
  assign w_stop  = io_bus.scl_in & io_bus.past_scl_in & ~io_bus.past_sda_in & io_bus.sda_in;
  assign w_rise  = io_bus.scl_in & ~io_bus.past_scl_in;
  assign w_fall  = ~io_bus.scl_in & io_bus.past_scl_in;
  // bcnt[3] is the wrap flag: set once eight bits have been sampled
  assign w_byte_done = r_bcnt[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bcnt      <= 4'd0;
      r_sreg      <= 8'd0;
      r_sda_oe    <= 1'b0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_addr_hit  <= 1'b0;
      r_rw        <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      if (w_stop) begin
        r_state    <= S_IDLE;
        r_bcnt     <= 4'd0;
        r_sda_oe   <= 1'b0;
        r_addr_hit <= 1'b0;
        r_busy     <= 1'b0;
        r_stop_det <= 1'b1;
      end else if (w_start) begin
        r_state     <= S_ADDR;
        r_bcnt      <= 4'd0;
        r_sreg      <= 8'd0;
        r_sda_oe    <= 1'b0;
        r_addr_hit  <= 1'b0;
        r_busy      <= 1'b1;
        r_start_det <= 1'b1;
      end else begin
        case (r_state)
          S_ADDR, S_DATA: begin
            if (w_rise && !w_byte_done) begin
              r_sreg <= {r_sreg[6:0], io_bus.sda_in};
              r_bcnt <= r_bcnt + 4'd1;
            end else if (w_fall && w_byte_done) begin
              if (r_state == S_ADDR) begin
                if (r_sreg[7:1] == SLAVE_ADDR) begin
                  r_state    <= S_ADDR_ACK;
                  r_addr_hit <= 1'b1;
                  r_rw       <= r_sreg[0];
                  r_sda_oe   <= GEN_ACK;
                end else begin
                  r_state <= S_IGNORE;
                end
              end else begin
                r_state    <= S_DATA_ACK;
                r_rx_data  <= r_sreg;
                r_rx_valid <= 1'b1;
                r_sda_oe   <= GEN_ACK;
              end
            end
          end
          S_ADDR_ACK, S_DATA_ACK: begin
            // ACK is held through the whole 9th clock and released on its falling edge
            if (w_fall) begin
              r_sda_oe <= 1'b0;
              r_bcnt   <= 4'd0;
              if (r_state == S_ADDR_ACK && r_rw) begin
                r_state <= S_IGNORE;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          S_IGNORE: begin
            r_sda_oe <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign io_bus.sda_oe    = r_sda_oe;
  assign io_bus.rx_data   = r_rx_data;
  assign io_bus.rx_valid  = r_rx_valid;
  assign io_bus.addr_hit  = r_addr_hit;
  assign io_bus.rw        = r_rw;
  assign io_bus.start_det = r_start_det;
  assign io_bus.stop_det  = r_stop_det;
  assign io_bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_byte_rx
// Brief    : Bench for i2c_byte_rx; one ACKing and one non-ACKing instance on
//            a shared bus, checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sda = 1'b1;
  logic scl = 1'b1;
  logic p_sda = 1'b1;
  logic p_scl = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p_sda <= sda;
    p_scl <= scl;
  end

  i2c_byte_rx_if b0();
  i2c_byte_rx_if b1();

  assign b0.sda_in = sda;
  assign b0.scl_in = scl;
  assign b0.past_sda_in = p_sda;
  assign b0.past_scl_in = p_scl;
  assign b1.sda_in = sda;
  assign b1.scl_in = scl;
  assign b1.past_sda_in = p_sda;
  assign b1.past_scl_in = p_scl;

  i2c_byte_rx #(.SLAVE_ADDR(7'h42), .GEN_ACK(1'b1)) u_ack  (.clk(clk), .rst(rst), .io_bus(b0));
  i2c_byte_rx #(.SLAVE_ADDR(7'h42), .GEN_ACK(1'b0)) u_nack (.clk(clk), .rst(rst), .io_bus(b1));

  logic [1:0] oe, rxv, hit, rwv, sdet, pdet, bsy;
  logic [7:0] rxd [2];
  assign oe   = {b1.sda_oe,    b0.sda_oe};
  assign rxv  = {b1.rx_valid,  b0.rx_valid};
  assign hit  = {b1.addr_hit,  b0.addr_hit};
  assign rwv  = {b1.rw,        b0.rw};
  assign sdet = {b1.start_det, b0.start_det};
  assign pdet = {b1.stop_det,  b0.stop_det};
  assign bsy  = {b1.busy,      b0.busy};
  assign rxd[0] = b0.rx_data;
  assign rxd[1] = b1.rx_data;

  // Pulse counters and received-byte log, one per instance
  int         nst [2] = '{0, 0};
  int         nsp [2] = '{0, 0};
  int         rxn [2] = '{0, 0};
  logic [7:0] rxbuf [2][512];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rxv[k]) begin
        if (rxn[k] < 512) rxbuf[k][rxn[k]] <= rxd[k];
        rxn[k] <= rxn[k] + 1;
      end
      if (sdet[k]) nst[k] <= nst[k] + 1;
      if (pdet[k]) nsp[k] <= nsp[k] + 1;
    end
  end

  int   vectors = 0;
  int   miscompares = 0;
  logic stray = 1'b0;
  logic model_rw = 1'b0;
  logic [7:0] last_rx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 1 = ACK clock: compare sda_oe of each instance against exp_ack
  task automatic put_bit(input logic b, input int mode, input logic [1:0] exp_ack);
    sda = b;
    tick(2);
    scl = 1'b1;
    tick(2);
    if (mode == 1) begin
      for (int k = 0; k < 2; k++) check($sformatf("ack_oe%0d", k), 32'(oe[k]), 32'(exp_ack[k]));
    end else if (oe != 2'b00) begin
      stray = 1'b1;
    end
    tick(2);
    scl = 1'b0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [1:0] exp_ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i], 0, 2'b00);
    put_bit(1'b1, 1, exp_ack);
  endtask

  task automatic bus_start();
    sda = 1'b1;
    tick(2);
    scl = 1'b1;
    tick(3);
    sda = 1'b0;
    tick(3);
    scl = 1'b0;
    tick(2);
  endtask

  task automatic bus_stop();
    sda = 1'b0;
    tick(2);
    scl = 1'b1;
    tick(3);
    sda = 1'b1;
    tick(3);
  endtask

  // One START..STOP transfer; instance 0 ACKs, instance 1 never does
  task automatic run_txn(input logic [7:0] ab, input logic [31:0] data, input int nd,
                         input logic exp_hit, input int exp_nrx);
    int   s0 [2];
    int   p0 [2];
    int   r0 [2];
    logic wr;
    wr = exp_hit && !ab[0];
    for (int k = 0; k < 2; k++) begin
      s0[k] = nst[k];
      p0[k] = nsp[k];
      r0[k] = rxn[k];
    end
    stray = 1'b0;
    bus_start();
    send_byte(ab, {1'b0, exp_hit});
    for (int i = 0; i < nd; i++) send_byte(data[31-8*i -: 8], {1'b0, wr});
    if (exp_hit) model_rw = ab[0];
    for (int k = 0; k < 2; k++) begin
      check($sformatf("addr_hit%0d", k), 32'(hit[k]), 32'(exp_hit));
      check($sformatf("rw%0d", k), 32'(rwv[k]), 32'(model_rw));
      check($sformatf("busy_in%0d", k), 32'(bsy[k]), 32'd1);
    end
    bus_stop();
    tick(2);
    if (exp_nrx > 0) last_rx = data[31-8*(exp_nrx-1) -: 8];
    for (int k = 0; k < 2; k++) begin
      check($sformatf("start_cnt%0d", k), 32'(nst[k] - s0[k]), 32'd1);
      check($sformatf("stop_cnt%0d", k), 32'(nsp[k] - p0[k]), 32'd1);
      check($sformatf("busy_out%0d", k), 32'(bsy[k]), 32'd0);
      check($sformatf("hit_out%0d", k), 32'(hit[k]), 32'd0);
      check($sformatf("oe_out%0d", k), 32'(oe[k]), 32'd0);
      check($sformatf("rx_cnt%0d", k), 32'(rxn[k] - r0[k]), 32'(exp_nrx));
      for (int i = 0; i < exp_nrx && i < rxn[k] - r0[k]; i++)
        check($sformatf("rx_byte%0d_%0d", k, i), 32'(rxbuf[k][r0[k] + i]), 32'(data[31-8*i -: 8]));
      check($sformatf("rx_hold%0d", k), 32'(rxd[k]), 32'(last_rx));
    end
    check("stray_oe", 32'(stray), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  ab;
    logic [31:0] data;
    int          nd;
    logic        exp_hit;
    int          exp_nrx;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int s0;
    int r0;
    logic [7:0]  ab;
    logic [31:0] dat;
    int          nd;
    logic        h;

    tbl[0] = '{ab: 8'h84, data: 32'hA5000000, nd: 1, exp_hit: 1'b1, exp_nrx: 1};
    tbl[1] = '{ab: 8'h86, data: 32'h11000000, nd: 1, exp_hit: 1'b0, exp_nrx: 0};
    tbl[2] = '{ab: 8'h85, data: 32'h5A000000, nd: 1, exp_hit: 1'b1, exp_nrx: 0};
    tbl[3] = '{ab: 8'h84, data: 32'h00FF7E00, nd: 3, exp_hit: 1'b1, exp_nrx: 3};

    tick(3);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_oe%0d", k), 32'(oe[k]), 32'd0);
      check($sformatf("rst_hit%0d", k), 32'(hit[k]), 32'd0);
      check($sformatf("rst_rw%0d", k), 32'(rwv[k]), 32'd0);
      check($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
      check($sformatf("rst_rxd%0d", k), 32'(rxd[k]), 32'd0);
      check($sformatf("rst_pulses%0d", k), 32'({rxv[k], sdet[k], pdet[k]}), 32'd0);
    end
    rst = 1'b0;
    tick(3);

    for (int t = 0; t < 4; t++)
      run_txn(tbl[t].ab, tbl[t].data, tbl[t].nd, tbl[t].exp_hit, tbl[t].exp_nrx);

    // Repeated START after a partial data byte
    s0 = nst[0];
    r0 = rxn[0];
    bus_start();
    send_byte(8'h84, 2'b01);
    put_bit(1'b1, 0, 2'b00);
    put_bit(1'b0, 0, 2'b00);
    put_bit(1'b1, 0, 2'b00);
    bus_start();
    check("rs_hit_clear", 32'(hit), 32'd0);
    check("rs_oe_clear", 32'(oe), 32'd0);
    send_byte(8'h84, 2'b01);
    send_byte(8'h3C, 2'b01);
    bus_stop();
    tick(2);
    last_rx = 8'h3C;
    model_rw = 1'b0;
    check("rs_start_cnt", 32'(nst[0] - s0), 32'd2);
    check("rs_rx_cnt", 32'(rxn[0] - r0), 32'd1);
    check("rs_rx_byte", 32'(rxbuf[0][r0]), 32'h3C);

    // Asynchronous reset while instance 0 is ACKing a data byte
    bus_start();
    send_byte(8'h84, 2'b01);
    for (int i = 7; i >= 0; i--) put_bit(1'(8'hA5 >> i), 0, 2'b00);
    check("pre_rst_oe", 32'(oe[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_oe", 32'(oe), 32'd0);
    check("async_hit", 32'(hit), 32'd0);
    check("async_busy", 32'(bsy), 32'd0);
    check("async_rxv", 32'(rxv), 32'd0);
    tick(2);
    rst = 1'b0;
    last_rx = 8'h00;
    model_rw = 1'b0;
    tick(2);
    s0 = nst[0];
    r0 = rxn[0];
    stray = 1'b0;
    send_byte(8'h84, 2'b00);
    check("idle_hit", 32'(hit), 32'd0);
    check("idle_busy", 32'(bsy), 32'd0);
    check("idle_start", 32'(nst[0] - s0), 32'd0);
    check("idle_rx", 32'(rxn[0] - r0), 32'd0);
    check("idle_rxd", 32'(rxd[0]), 32'd0);
    check("idle_stray", 32'(stray), 32'd0);
    scl = 1'b1;
    tick(3);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 2) != 0) ab = {7'h42, 1'($urandom_range(0, 1))};
      else ab = 8'($urandom);
      dat = $urandom;
      nd  = $urandom_range(0, 3);
      h   = (ab[7:1] == 7'h42);
      run_txn(ab, dat, nd, h, (h && !ab[0]) ? nd : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
